// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART receiver.
// UART_RX_PARITY_EN adds the PARITY state to the receiver FSM.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
`ifdef UART_RX_PARITY_EN
    , ST_PARITY = 3'd5
`endif
  } state_e;

  function automatic int clocks_per_baud(input int input_clock, input int baud);
    return input_clock / baud;
  endfunction

  function automatic int half_bit(input int clock_per_baud);
    return clock_per_baud / 2;
  endfunction

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Reloadable down-counter: after a load of N cycles, o_tick is high exactly N edges later.
`timescale 1ns/1ps
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLOCK_PER_BAUD = 138,
  parameter int HALF_BIT       = 69,
  localparam int CNT_W         = $clog2(CLOCK_PER_BAUD)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_load_half,
  input  logic i_load_full,
  output logic o_tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Loads take priority; counting stops at zero until the next load.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load_half) begin
      cnt_d = CNT_W'(HALF_BIT - 1);
    end else if (i_load_full) begin
      cnt_d = CNT_W'(CLOCK_PER_BAUD - 1);
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = i_en && (cnt_q == '0);

endmodule

// File: rtl/uart_receiver.sv
// 8-bit UART receiver with acknowledge handshake, frame/overrun reporting and break handling.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop.
`timescale 1ns/1ps
module uart_receiver
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK = 16_000_000,
  parameter int BAUD        = 115_200
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_new_data,
  input  logic                 i_ack_data,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CLOCK_PER_BAUD = clocks_per_baud(INPUT_CLOCK, BAUD);
  localparam int HALF_BIT       = half_bit(CLOCK_PER_BAUD);

  state_e               state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 rx_prev_q;
  logic                 new_data_q, new_data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 load_half_s, load_full_s, cnt_en_s, tick_s;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err_q, parity_err_d;
  logic                 par_bad_q, par_bad_d;
`else
  logic                 par_bad_q;
  assign par_bad_q = 1'b0;
`endif

  assign cnt_en_s = (state_q != ST_IDLE) && (state_q != ST_BREAK);

  uart_baud_counter #(
    .CLOCK_PER_BAUD (CLOCK_PER_BAUD),
    .HALF_BIT       (HALF_BIT)
  ) u_baud_counter (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (cnt_en_s),
    .i_load_half (load_half_s),
    .i_load_full (load_full_s),
    .o_tick      (tick_s)
  );

  // Frame FSM; a start needs a falling edge so a line held low after reset is ignored.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
    load_half_s = 1'b0;
    load_full_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
    par_bad_d    = par_bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!i_rx && rx_prev_q) begin
          state_d     = ST_START;
          load_half_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          if (!i_rx) begin
            state_d     = ST_DATA;
            bit_cnt_d   = 3'd0;
            load_full_s = 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad_d   = 1'b0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_d     = {i_rx, shift_q[DATA_BITS-1:1]};
          bit_cnt_d   = bit_cnt_q + 3'd1;
          load_full_s = 1'b1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          state_d     = ST_STOP;
          load_full_s = 1'b1;
          if (i_rx != even_parity(shift_q)) begin
            parity_err_d = 1'b1;
            par_bad_d    = 1'b1;
          end else begin
            par_bad_d = 1'b0;
          end
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          if (i_rx) begin
            state_d = ST_IDLE;
            done_d  = !par_bad_q;
          end else begin
            state_d     = ST_BREAK;
            frame_err_d = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (i_rx) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Delivery and handshake: a completing frame with a same-cycle ack replaces the held byte.
  always_comb begin
    data_d     = data_q;
    new_data_d = new_data_q;
    overrun_d  = overrun_q;
    if (done_q) begin
      if (new_data_q && !i_ack_data) begin
        overrun_d = 1'b1;
      end else begin
        data_d     = shift_q;
        new_data_d = 1'b1;
        if (new_data_q) begin
          overrun_d = 1'b0;
        end else begin
          overrun_d = overrun_q;
        end
      end
    end else if (new_data_q && i_ack_data) begin
      new_data_d = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      new_data_d = new_data_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      done_q      <= 1'b0;
      rx_prev_q   <= 1'b0;
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      done_q      <= done_d;
      rx_prev_q   <= i_rx;
      new_data_q  <= new_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
    end
  end
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_data      = data_q;
  assign o_new_data  = new_data_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver at default timing (138 clocks per bit).
// Honours UART_RX_PARITY_EN to exercise the parity build.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int CPB = 138;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam int RISE  = 1450;
`else
  localparam int NBITS = 10;
  localparam int RISE  = 1312;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_ack_data = 1'b0;
  logic [7:0] o_data;
  logic       o_new_data, o_frame_err, o_parity_err, o_overrun, o_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int rise_cyc, ferr_cnt, perr_cnt, busy_after_rst;
  logic [7:0] snap_data;
  logic snap_nd, snap_busy, snap_ovr, snap_ferr;

  always #5 i_clk = ~i_clk;

  uart_receiver dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_new_data   (o_new_data),
    .i_ack_data   (i_ack_data),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_overrun    (o_overrun),
    .o_busy       (o_busy)
  );

  // Drives one frame; iteration c sets the line before clock edge c (edge 0 sees the start bit).
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input int ack_cyc, input int rst_cyc);
    logic [10:0] bits;
    logic prev_nd;
`ifdef UART_RX_PARITY_EN
    bits = {stop_b, par_b, d, 1'b0};
`else
    bits = {par_b, stop_b, d, 1'b0};
`endif
    rise_cyc = -1; ferr_cnt = 0; perr_cnt = 0; busy_after_rst = 0;
    prev_nd = o_new_data;
    for (int c = 0; c < NBITS * CPB; c++) begin
      i_rx = bits[c / CPB];
      i_ack_data = (c == ack_cyc);
      i_rst_n = !((rst_cyc >= 0) && (c >= rst_cyc) && (c < rst_cyc + 2));
      @(posedge i_clk); #1;
      if (o_new_data && !prev_nd && rise_cyc < 0) rise_cyc = c;
      prev_nd = o_new_data;
      if (o_frame_err) ferr_cnt++;
      if (o_parity_err) perr_cnt++;
      if (c == rst_cyc) begin
        snap_data = o_data; snap_nd = o_new_data; snap_busy = o_busy;
        snap_ovr = o_overrun; snap_ferr = o_frame_err;
      end
      if ((rst_cyc >= 0) && (c > rst_cyc + 1) && o_busy) busy_after_rst++;
    end
    i_ack_data = 1'b0;
    i_rst_n = 1'b1;
    i_rx = 1'b1;
  endtask

  task automatic pulse_ack();
    i_ack_data = 1'b1;
    @(posedge i_clk); #1;
    i_ack_data = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_rx = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    n_cmp++; if (o_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", o_data); end
    n_cmp++; if ({o_new_data, o_frame_err, o_parity_err, o_overrun, o_busy} !== 5'b00000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00000", {o_new_data, o_frame_err, o_parity_err, o_overrun, o_busy}); end
    i_rst_n = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
    n_cmp++; if (rise_cyc != RISE) begin n_bad++; $display("FAIL basic_rise: got %0d want %0d", rise_cyc, RISE); end
    n_cmp++; if (o_data !== 8'hA5) begin n_bad++; $display("FAIL basic_data: got %h want a5", o_data); end
    n_cmp++; if (ferr_cnt != 0 || perr_cnt != 0) begin n_bad++; $display("FAIL basic_errs: got %0d/%0d want 0/0", ferr_cnt, perr_cnt); end
    n_cmp++; if (o_overrun !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_ovr_busy: got %b%b want 00", o_overrun, o_busy); end
    pulse_ack();
    n_cmp++; if (o_new_data !== 1'b0 || o_data !== 8'hA5) begin n_bad++; $display("FAIL basic_ack: got nd=%b data=%h want 0/a5", o_new_data, o_data); end
    pulse_ack();
    n_cmp++; if (o_new_data !== 1'b0 || o_overrun !== 1'b0) begin n_bad++; $display("FAIL idle_ack: got nd=%b ovr=%b want 0/0", o_new_data, o_overrun); end
  endtask

  task automatic test_false_start();
    logic b1, b70;
    int hits;
    b1 = 1'b0; b70 = 1'b1; hits = 0;
    for (int c = 0; c < 100; c++) begin
      i_rx = (c < 40) ? 1'b0 : 1'b1;
      @(posedge i_clk); #1;
      if (c == 1) b1 = o_busy;
      if (c == 70) b70 = o_busy;
      if (o_new_data || o_frame_err || o_parity_err || o_overrun) hits++;
    end
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL false_start_busy1: got %b want 1", b1); end
    n_cmp++; if (b70 !== 1'b0) begin n_bad++; $display("FAIL false_start_busy70: got %b want 0", b70); end
    n_cmp++; if (hits != 0) begin n_bad++; $display("FAIL false_start_flags: got %0d want 0", hits); end
  endtask

  task automatic test_frame_err();
    int idle_cnt;
    idle_cnt = 0;
    send_frame(8'h3C, 1'b0, ~^8'h3C, -1, -1);
    i_rx = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge i_clk); #1;
      if (!o_busy) idle_cnt++;
      if (o_frame_err) ferr_cnt++;
    end
    n_cmp++; if (ferr_cnt != 1) begin n_bad++; $display("FAIL frame_err_pulses: got %0d want 1", ferr_cnt); end
    n_cmp++; if (rise_cyc != -1 || o_new_data !== 1'b0) begin n_bad++; $display("FAIL frame_err_nodata: got rise=%0d nd=%b want -1/0", rise_cyc, o_new_data); end
    n_cmp++; if (idle_cnt != 0) begin n_bad++; $display("FAIL break_hold: got %0d idle cycles want 0", idle_cnt); end
    i_rx = 1'b1;
    @(posedge i_clk); #1;
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL break_exit: got busy=%b want 0", o_busy); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, ^8'h11, -1, -1);
    send_frame(8'h22, 1'b1, ^8'h22, -1, -1);
    n_cmp++; if (o_data !== 8'h11 || o_new_data !== 1'b1) begin n_bad++; $display("FAIL overrun_keep: got data=%h nd=%b want 11/1", o_data, o_new_data); end
    n_cmp++; if (o_overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b want 1", o_overrun); end
    pulse_ack();
    n_cmp++; if (o_new_data !== 1'b0 || o_overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_ack: got nd=%b ovr=%b want 0/0", o_new_data, o_overrun); end
  endtask

  task automatic test_ack_same_cycle();
    send_frame(8'h44, 1'b1, ^8'h44, -1, -1);
    send_frame(8'h55, 1'b1, ^8'h55, RISE, -1);
    n_cmp++; if (o_data !== 8'h55) begin n_bad++; $display("FAIL same_cycle_data: got %h want 55", o_data); end
    n_cmp++; if (o_new_data !== 1'b1 || o_overrun !== 1'b0) begin n_bad++; $display("FAIL same_cycle_flags: got nd=%b ovr=%b want 1/0", o_new_data, o_overrun); end
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h81, 1'b1, ^8'h81, -1, -1);
    send_frame(8'h7E, 1'b1, ^8'h7E, 200, -1);
    n_cmp++; if (rise_cyc != RISE || o_data !== 8'h7E) begin n_bad++; $display("FAIL back_to_back: got rise=%0d data=%h want %0d/7e", rise_cyc, o_data, RISE); end
    n_cmp++; if (o_overrun !== 1'b0) begin n_bad++; $display("FAIL back_to_back_ovr: got %b want 0", o_overrun); end
    pulse_ack();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b0, -1, -1);
    n_cmp++; if (perr_cnt != 1) begin n_bad++; $display("FAIL parity_err_pulse: got %0d want 1", perr_cnt); end
    n_cmp++; if (rise_cyc != -1 || o_new_data !== 1'b0) begin n_bad++; $display("FAIL parity_discard: got rise=%0d nd=%b want -1/0", rise_cyc, o_new_data); end
    send_frame(8'h07, 1'b1, 1'b1, -1, -1);
    n_cmp++; if (o_data !== 8'h07 || perr_cnt != 0 || rise_cyc != RISE) begin
      n_bad++; $display("FAIL parity_ok: got data=%h perr=%0d rise=%0d want 07/0/%0d", o_data, perr_cnt, rise_cyc, RISE); end
    pulse_ack();
  endtask
`endif

  task automatic test_reset_mid_frame();
    send_frame(8'hA5, 1'b1, ^8'hA5, -1, -1);
    send_frame(8'h00, 1'b1, 1'b0, -1, 600);
    n_cmp++; if (snap_data !== 8'h00 || snap_nd !== 1'b0) begin n_bad++; $display("FAIL mid_reset_data: got data=%h nd=%b want 00/0", snap_data, snap_nd); end
    n_cmp++; if ({snap_busy, snap_ovr, snap_ferr} !== 3'b000) begin n_bad++; $display("FAIL mid_reset_flags: got %b want 000", {snap_busy, snap_ovr, snap_ferr}); end
    n_cmp++; if (busy_after_rst != 0 || rise_cyc != -1 || o_new_data !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_restart: got busy=%0d rise=%0d nd=%b want 0/-1/0", busy_after_rst, rise_cyc, o_new_data); end
    n_cmp++; if (ferr_cnt != 0 || perr_cnt != 0) begin n_bad++; $display("FAIL mid_reset_errs: got %0d/%0d want 0/0", ferr_cnt, perr_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_ack_same_cycle();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter INPUT_CLOCK, default 16_000_000, meaning the i_clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, meaning the serial bit rate.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port i_rx, input, 1 bit: serial line, idle high, already synchronised to i_clk by the caller.
REQ-006 SHALL have port o_data, output, 8 bits: the received byte, valid while o_new_data is high.
REQ-007 SHALL have port o_new_data, output, 1 bit: a byte is held and awaiting acknowledge.
REQ-008 SHALL have port i_ack_data, input, 1 bit: the consumer has taken o_data.
REQ-009 SHALL have port o_frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port o_parity_err, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-011 SHALL have port o_overrun, output, 1 bit: sticky flag, a frame was lost while o_new_data was high.
REQ-012 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL use CLOCK_PER_BAUD = INPUT_CLOCK/BAUD (integer division, 138 at defaults) and HALF_BIT = CLOCK_PER_BAUD/2 (69); the counter width is $clog2(CLOCK_PER_BAUD).
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY (macro only), STOP and BREAK.
REQ-015 SHALL treat the first cycle i_rx is low in IDLE as cycle 0 of a frame and move to START.
REQ-016 In START, SHALL sample i_rx at cycle HALF_BIT: low -> DATA; high -> IDLE as a false start, with no flags raised.
REQ-017 SHALL sample data bit k (k = 0..7, LSB first) at cycle HALF_BIT + CLOCK_PER_BAUD*(k+1).
REQ-018 SHALL sample the stop bit one CLOCK_PER_BAUD after the last data or parity bit (cycle 1311 at defaults without parity).
REQ-019 If the stop bit is high and no parity error occurred, SHALL load o_data and raise o_new_data on the following cycle, then go to IDLE.
REQ-020 If the stop bit is low, SHALL pulse o_frame_err, discard the byte, and go to BREAK; BREAK SHALL go to IDLE on the first cycle i_rx is high.
REQ-021 SHALL hold o_new_data and o_data stable until i_ack_data is sampled high; o_new_data SHALL clear on the next cycle.
REQ-022 SHALL ignore i_ack_data while o_new_data is low.
REQ-023 If a valid frame completes while o_new_data is high and i_ack_data is low, SHALL keep the old o_data, drop the new byte and set o_overrun.
REQ-024 If a valid frame completes in the same cycle that i_ack_data is high, SHALL load the new byte, keep o_new_data high and not set o_overrun.
REQ-025 SHALL clear o_overrun only on an accepted i_ack_data.
REQ-026 SHALL receive back-to-back frames with no idle gap: a start edge seen in IDLE right after STOP is accepted.

Reset
REQ-027 With i_rst_n low at a clock edge: state IDLE, counters 0, o_data 8'h00, o_new_data 0, o_frame_err 0, o_parity_err 0, o_overrun 0, o_busy 0.
REQ-028 Reset mid-frame SHALL abandon the frame without a flag; reception SHALL restart only at a new falling edge after reset is released.

Configuration
REQ-029 With macro UART_RX_PARITY_EN defined: PARITY state after bit 7, even parity bit sampled at cycle HALF_BIT + CLOCK_PER_BAUD*9, stop bit one baud later (cycle 1449); mismatch pulses o_parity_err and discards the byte.
REQ-030 Without UART_RX_PARITY_EN: there is no PARITY state, o_parity_err is tied 0 and the frame is 8N1.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum, the CLOCK_PER_BAUD/HALF_BIT derivation function, and DATA_BITS = 8.
REQ-032 Sub-module uart_baud_counter SHALL hold the reloadable cycle counter (load HALF_BIT or CLOCK_PER_BAUD, one-cycle tick output); the rest stays in uart_receiver.

Verification
REQ-033 Send 0xA5 as 8N1 at default timing -> o_new_data rises at cycle 1312, o_data = 0xA5, no flags raised.
REQ-034 Pulse i_rx low for 40 cycles in IDLE -> no o_new_data, no flags, o_busy back to 0 by cycle 70.
REQ-035 Send 0x3C with a low stop bit, then hold i_rx low for 500 cycles -> one o_frame_err pulse, no o_new_data, BREAK held until i_rx goes high.
REQ-036 Send 0x11 then 0x22 without an ack -> o_data = 0x11, o_overrun = 1; ack -> o_new_data 0 and o_overrun 0 the next cycle.
REQ-037 Assert ack in the completion cycle of 0x55 while 0x44 is pending -> o_data = 0x55, o_new_data stays 1, o_overrun = 0.
REQ-038 Under UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> o_parity_err pulse, no o_new_data; send 0x07 with parity bit 1 -> o_data = 0x07. Assert i_rst_n low at cycle 600 of any frame -> all outputs at reset values, no delivery.
